// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared widths, writeback entry type and grant encoding
package regfile_pkg;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic [ADDR_W-1:0] dest;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    typedef enum logic {
        GRANT_ALU = 1'b0,
        GRANT_MEM = 1'b1
    } grant_e;
endpackage

// File: rtl/regfile_writeback_if.sv
// rtl/regfile_writeback_if.sv - result source channel (valid/ready with dest and data)
interface regfile_writeback_if;
    import regfile_pkg::*;

    logic              valid;
    logic              ready;
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] data;

    modport master (output valid, output dest, output data, input ready);
    modport slave  (input valid, input dest, input data, output ready);
endinterface

// File: rtl/regfile_writeback_fifo.sv
// rtl/regfile_writeback_fifo.sv - synchronous writeback buffer with wrap-around pointers
module wb_fifo
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  wb_entry_t                push_entry_i,
    input  logic                     pop_i,
    output wb_entry_t                head_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // Pushes are checked against the pre-pop count, so a full FIFO never accepts.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_entry_i;
    end
endmodule

// File: rtl/regfile_writeback.sv
// rtl/regfile_writeback.sv - round-robin result arbiter, buffered register write port, busy scoreboard
module regfile_writeback
    import regfile_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    regfile_writeback_if.slave  alu,
    regfile_writeback_if.slave  mem,
    input  logic                wb_hold,
    input  logic                issue_en,
    input  logic [ADDR_W-1:0]   issue_dest,
    output logic                reg_write_en,
    output logic [ADDR_W-1:0]   reg_write_dest,
    output logic [DATA_W-1:0]   reg_write_data,
    output logic [NUM_REGS-1:0] busy_mask
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    grant_e              last_grant_q, last_grant_d;
    logic                wr_en_q, wr_en_d;
    wb_entry_t           wr_q, wr_d;
    logic [NUM_REGS-1:0] busy_q, busy_d;

    logic                grant_mem, accept, push, pop, bypass, fifo_push;
    wb_entry_t           in_entry, head;
    logic [CNT_W-1:0]    fifo_count;
    logic                fifo_full, fifo_empty;

    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push_i       (fifo_push),
        .push_entry_i (in_entry),
        .pop_i        (pop),
        .head_o       (head),
        .count_o      (fifo_count),
        .full_o       (fifo_full),
        .empty_o      (fifo_empty)
    );

    always_comb begin
        grant_mem = mem.valid && (!alu.valid || last_grant_q == GRANT_ALU);
        alu.ready = rst && !fifo_full && !grant_mem;
        mem.ready = rst && !fifo_full && grant_mem;
        accept    = (alu.valid && alu.ready) || (mem.valid && mem.ready);

        if (grant_mem) begin
            in_entry.dest = mem.dest;
            in_entry.data = mem.data;
        end else begin
            in_entry.dest = alu.dest;
            in_entry.data = alu.data;
        end

        // Results for r0 are consumed without touching the buffer or the write port.
        push      = accept && (in_entry.dest != ZERO_REG);
        pop       = (fifo_count != '0) && !wb_hold;
        // An empty buffer forwards the new result straight to the write registers.
        bypass    = fifo_empty && push && !wb_hold;
        fifo_push = push && !bypass;

        last_grant_d = last_grant_q;
        if (accept) last_grant_d = grant_mem ? GRANT_MEM : GRANT_ALU;

        wr_en_d = pop || bypass;
        wr_d    = wr_q;
        if (pop)         wr_d = head;
        else if (bypass) wr_d = in_entry;

        // Clear for the committing write first so a same-cycle reservation wins.
        busy_d = busy_q;
        if (wr_en_q) busy_d[wr_q.dest] = 1'b0;
        if (issue_en && issue_dest != ZERO_REG) busy_d[issue_dest] = 1'b1;
        busy_d[ZERO_REG] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant_q <= GRANT_ALU;
            wr_en_q      <= 1'b0;
            wr_q         <= '0;
            busy_q       <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            wr_en_q      <= wr_en_d;
            wr_q         <= wr_d;
            busy_q       <= busy_d;
        end
    end

    assign reg_write_en   = wr_en_q;
    assign reg_write_dest = wr_q.dest;
    assign reg_write_data = wr_q.data;
    assign busy_mask      = busy_q;
endmodule

// File: tb/tb_regfile_writeback.sv
// tb/tb_regfile_writeback.sv - randomized and directed bench against a queue-based writeback model
module tb_regfile_writeback;
    import regfile_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    regfile_writeback_if alu_if ();
    regfile_writeback_if mem_if ();

    logic                wb_hold, issue_en;
    logic [ADDR_W-1:0]   issue_dest;
    logic                reg_write_en;
    logic [ADDR_W-1:0]   reg_write_dest;
    logic [DATA_W-1:0]   reg_write_data;
    logic [NUM_REGS-1:0] busy_mask;

    regfile_writeback #(.FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .alu            (alu_if),
        .mem            (mem_if),
        .wb_hold        (wb_hold),
        .issue_en       (issue_en),
        .issue_dest     (issue_dest),
        .reg_write_en   (reg_write_en),
        .reg_write_dest (reg_write_dest),
        .reg_write_data (reg_write_data),
        .busy_mask      (busy_mask)
    );

    // Reference: results accepted but not yet written, in acceptance order.
    wb_entry_t         pend_q[$];
    bit                model_busy [NUM_REGS];
    bit                last_was_alu;
    bit                exp_wen;
    logic [ADDR_W-1:0] exp_dest;
    logic [DATA_W-1:0] exp_data;
    int                n_vec = 0;
    int                n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        pend_q.delete();
        for (int i = 0; i < NUM_REGS; i++) model_busy[i] = 1'b0;
        last_was_alu = 1'b1;
        exp_wen  = 1'b0;
        exp_dest = '0;
        exp_data = '0;
    endtask

    // Entered and left 1 time unit after a rising edge, with this cycle's inputs driven.
    task automatic cycle();
        bit                  g_mem, room, alu_acc, mem_acc;
        wb_entry_t           w;
        logic [NUM_REGS-1:0] exp_busy;
        #1;
        g_mem = mem_if.valid && (!alu_if.valid || last_was_alu);
        room  = pend_q.size() < DEPTH;
        if (alu_if.valid || mem_if.valid) begin
            chk("alu_ready", alu_if.ready, room && !g_mem);
            chk("mem_ready", mem_if.ready, room && g_mem);
        end
        alu_acc = alu_if.valid && room && !g_mem;
        mem_acc = mem_if.valid && room && g_mem;
        if (alu_acc || mem_acc) begin
            last_was_alu = alu_acc;
            w.dest = mem_acc ? mem_if.dest : alu_if.dest;
            w.data = mem_acc ? mem_if.data : alu_if.data;
            if (w.dest != '0) pend_q.push_back(w);
        end
        if (exp_wen) model_busy[exp_dest] = 1'b0;
        if (issue_en && issue_dest != '0) model_busy[issue_dest] = 1'b1;
        if (!wb_hold && pend_q.size() > 0) begin
            w = pend_q.pop_front();
            exp_wen  = 1'b1;
            exp_dest = w.dest;
            exp_data = w.data;
        end else begin
            exp_wen = 1'b0;
        end
        @(posedge clk);
        #1;
        if (alu_acc) alu_if.valid = 1'b0;
        if (mem_acc) mem_if.valid = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) exp_busy[i] = model_busy[i];
        chk("wr_en", reg_write_en, exp_wen);
        chk("wr_dest", reg_write_dest, exp_dest);
        chk("wr_data", reg_write_data, exp_data);
        chk("busy_mask", busy_mask, exp_busy);
    endtask

    task automatic drive_alu(input logic [ADDR_W-1:0] d, input logic [DATA_W-1:0] x);
        alu_if.valid = 1'b1;
        alu_if.dest  = d;
        alu_if.data  = x;
    endtask

    initial begin
        alu_if.valid = 1'b0; alu_if.dest = '0; alu_if.data = '0;
        mem_if.valid = 1'b0; mem_if.dest = '0; mem_if.data = '0;
        wb_hold = 1'b0; issue_en = 1'b0; issue_dest = '0;
        model_reset();

        // Power-on reset values.
        @(posedge clk); #1;
        chk("por_wen", reg_write_en, 0);
        chk("por_dest", reg_write_dest, 0);
        chk("por_data", reg_write_data, 0);
        chk("por_busy", busy_mask, 0);
        #2 rst = 1'b1;
        @(posedge clk); #1;

        // Tie: mem wins first, then alu.
        drive_alu(5'd3, 32'h11);
        mem_if.valid = 1'b1; mem_if.dest = 5'd7; mem_if.data = 32'h22;
        cycle();
        chk("tie_first_dest", reg_write_dest, 7);
        cycle();
        chk("tie_second_dest", reg_write_dest, 3);
        chk("tie_second_en", reg_write_en, 1);
        cycle();

        // Single write with scoreboard reservation.
        issue_en = 1'b1; issue_dest = 5'd5;
        cycle();
        issue_en = 1'b0;
        drive_alu(5'd5, 32'hDEADBEEF);
        cycle();
        chk("single_en", reg_write_en, 1);
        chk("single_data", reg_write_data, 32'hDEADBEEF);
        chk("single_busy5_set", busy_mask[5], 1);
        cycle();
        chk("single_busy5_clr", busy_mask[5], 0);

        // Fill under hold, then drain; repeated so the pointers wrap.
        for (int rep = 0; rep < 3; rep++) begin
            wb_hold = 1'b1;
            for (int i = 1; i <= 4; i++) begin
                drive_alu(ADDR_W'(i), $urandom);
                cycle();
            end
            drive_alu(5'd6, $urandom);
            cycle();
            chk("full_ready", alu_if.ready, 0);
            wb_hold = 1'b0;
            for (int i = 1; i <= 4; i++) begin
                cycle();
                chk("drain_dest", reg_write_dest, i);
            end
            cycle();
            chk("drain_late_dest", reg_write_dest, 6);
            cycle();
        end

        // Destination r0 is swallowed.
        drive_alu(5'd0, 32'hFFFFFFFF);
        cycle();
        chk("dest0_no_write", reg_write_en, 0);
        chk("dest0_busy0", busy_mask[0], 0);

        // Reservation in the same cycle as the commit to that register.
        issue_en = 1'b1; issue_dest = 5'd9;
        cycle();
        issue_en = 1'b0;
        drive_alu(5'd9, 32'h99);
        cycle();
        issue_en = 1'b1; issue_dest = 5'd9;
        cycle();
        issue_en = 1'b0;
        chk("collide_busy9", busy_mask[9], 1);
        cycle();

        // Asynchronous reset with three buffered entries and a pending source.
        wb_hold = 1'b1;
        issue_en = 1'b1; issue_dest = 5'd12;
        for (int i = 0; i < 3; i++) begin
            drive_alu(ADDR_W'(20 + i), $urandom);
            cycle();
            issue_en = 1'b0;
        end
        drive_alu(5'd23, 32'h23);
        #2 rst = 1'b0;
        #1;
        chk("arst_wen", reg_write_en, 0);
        chk("arst_busy", busy_mask, 0);
        chk("arst_alu_ready", alu_if.ready, 0);
        chk("arst_dest", reg_write_dest, 0);
        model_reset();
        alu_if.valid = 1'b0; wb_hold = 1'b0;
        @(posedge clk); #3;
        rst = 1'b1;
        @(posedge clk); #1;
        drive_alu(5'd4, 32'h44);
        cycle();
        for (int i = 0; i < 4; i++) cycle();

        // Randomized traffic.
        for (int k = 0; k < 400; k++) begin
            if (!alu_if.valid && $urandom_range(0, 1) == 1)
                drive_alu(ADDR_W'($urandom_range(0, NUM_REGS - 1)), $urandom);
            if (!mem_if.valid && $urandom_range(0, 1) == 1) begin
                mem_if.valid = 1'b1;
                mem_if.dest  = ADDR_W'($urandom_range(0, NUM_REGS - 1));
                mem_if.data  = $urandom;
            end
            wb_hold    = ($urandom_range(0, 3) == 0);
            issue_en   = ($urandom_range(0, 1) == 1);
            issue_dest = ADDR_W'($urandom_range(0, NUM_REGS - 1));
            cycle();
        end
        issue_en = 1'b0; wb_hold = 1'b0;
        for (int i = 0; i < 10; i++) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
